inha_key_event_encoder: RTL and testbench

//  Input-side front end for the inha game core. Takes the active-low push-buttons (L,R,U,D)
//  and switches (SW0..SW3). Synchronises and debounces each one, and detects presses.

---
 rtl/inha_key_pkg.sv | 26 ++
 rtl/inha_key_debounce.sv | 93 +++++++++
 rtl/inha_key_event_encoder.sv | 118 +++++++++++
 tb/tb_inha_key_event_encoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inha_key_pkg.sv
// inha_key_pkg
//   Shared types and constants for the inha key event encoder.
//   - NUM_KEYS  : number of key inputs handled by the encoder
//   - ev_code_t : 3-bit event code, equal to the key index
//   Optional feature macro used by the encoder files: KEY_REPEAT_EN
package inha_key_pkg;

   localparam int NUM_KEYS = 8;

   typedef enum logic [2:0] {
      KEY_L   = 3'd0,
      KEY_R   = 3'd1,
      KEY_U   = 3'd2,
      KEY_D   = 3'd3,
      KEY_SW0 = 3'd4,
      KEY_SW1 = 3'd5,
      KEY_SW2 = 3'd6,
      KEY_SW3 = 3'd7
   } ev_code_t;

   // Event code for a key index (index and code are the same number).
   function automatic ev_code_t key_to_code(input logic [2:0] idx);
      return ev_code_t'(idx);
   endfunction

endpackage

// File: rtl/inha_key_debounce.sv
// inha_key_debounce
//   One key's input path: 2-flop synchroniser on the inverted raw input,
//   a debounce counter, press detection and (with KEY_REPEAT_EN defined)
//   an auto-repeat counter.
//   Parameters:
//     DB_CYCLES      consecutive differing samples before the level flips (>=1)
//     REPEAT_CYCLES  edges held per repeat pulse (only with KEY_REPEAT_EN)
//   Ports:
//     clk    in   system clock, rising edge
//     rst    in   asynchronous active-high reset
//     key_n  in   raw active-low key
//     level  out  debounced level, 1 = pressed
//     press  out  one-cycle pulse the cycle after level rises
//     rpt    out  one-cycle repeat pulse while held (constant 0 without KEY_REPEAT_EN)
//   Configuration macro: KEY_REPEAT_EN
module inha_key_debounce #(
   parameter int DB_CYCLES = 1
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_CYCLES = 16
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic press,
   output logic rpt
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic          sync1;
   logic          sync2;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] db_cnt;

   // Sync flops reset to "released" so a key held through reset still
   // produces a rising level and hence one press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level_q <= 1'b0;
         level_d <= 1'b0;
         db_cnt  <= '0;
      end else begin
         sync1   <= ~key_n;
         sync2   <= sync1;
         level_d <= level_q;
         if (sync2 != level_q) begin
            if (db_cnt == CW'(DB_CYCLES - 1)) begin
               level_q <= sync2;
               db_cnt  <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign level = level_q;
   // Registered copy of the level makes the press a single-cycle pulse.
   assign press = level_q & ~level_d;

`ifdef KEY_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

   logic [RW-1:0] rep_cnt;
   logic          rep_hit;

   assign rep_hit = (rep_cnt == RW'(REPEAT_CYCLES - 1));

   // Counts edges spent pressed; wraps on every REPEAT_CYCLES-th edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt <= '0;
      end else if (!level_q || rep_hit) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + 1'b1;
      end
   end

   assign rpt = level_q & rep_hit;
`else
   assign rpt = 1'b0;
`endif

endmodule

// File: rtl/inha_key_event_encoder.sv
// inha_key_event_encoder
//   Input front end for the inha game core. Debounces the 4 push-buttons
//   and 4 switches, turns each press into a 3-bit event code, and queues
//   the codes in a first-word-fall-through FIFO.
//   Parameters:
//     DB_CYCLES      debounce length in samples (>=1)
//     FIFO_DEPTH     event FIFO entries (power of 2, >=2)
//     REPEAT_CYCLES  auto-repeat period (only with KEY_REPEAT_EN)
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-high reset
//     key_n      in   [7:0] raw active-low keys: L,R,U,D,SW0..SW3
//     ev_valid   out  FIFO head holds an event
//     ev_code    out  [2:0] head event code (key index), 0 when empty
//     ev_ready   in   consumer accepts the head this cycle
//     key_level  out  [7:0] debounced levels, 1 = pressed
//     overflow   out  sticky, a press was lost; cleared by rst only
//   Handshake: an event transfers on every rising edge where ev_valid and
//   ev_ready are both 1; ev_code is stable while ev_valid is held; ev_ready
//   while ev_valid is 0 has no effect.
//   Configuration macro: KEY_REPEAT_EN
module inha_key_event_encoder
   import inha_key_pkg::*;
#(
   parameter int DB_CYCLES  = 1,
   parameter int FIFO_DEPTH = 4
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_CYCLES = 16
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic                ev_valid,
   output logic [2:0]          ev_code,
   input  logic                ev_ready,
   output logic [NUM_KEYS-1:0] key_level,
   output logic                overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] rpt;
   logic [NUM_KEYS-1:0] pending;
   logic [NUM_KEYS-1:0] clr_mask;

   ev_code_t            mem [FIFO_DEPTH];
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [AW:0]         count;
   logic                full;
   logic                pop;
   logic                push;
   logic                grant_valid;
   ev_code_t            grant_idx;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      inha_key_debounce #(
         .DB_CYCLES     (DB_CYCLES)
`ifdef KEY_REPEAT_EN
         ,
         .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .key_n (key_n[i]),
         .level (key_level[i]),
         .press (press[i]),
         .rpt   (rpt[i])
      );
   end

   // Lowest-index pending bit wins: scan downward so lower indices override.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = KEY_L;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            grant_valid = 1'b1;
            grant_idx   = key_to_code(3'(i));
         end
      end
   end

   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == (AW + 1)'(FIFO_DEPTH));
   assign ev_valid = (count != '0);
   assign pop      = ev_valid & ev_ready;
   // A pop frees the slot on the same edge, so a full FIFO can still accept.
   assign push     = grant_valid & (~full | pop);
   assign clr_mask = push ? (NUM_KEYS'(1) << grant_idx) : '0;
   assign ev_code  = ev_valid ? mem[rd_ptr[AW-1:0]] : KEY_L;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         pending <= (pending & ~clr_mask) | press | rpt;
         // A press onto a bit that is not leaving this edge is a lost event.
         // Repeats merge silently and never count as loss.
         if (|(press & pending & ~clr_mask)) overflow <= 1'b1;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= grant_idx;
   end

endmodule

// File: tb/tb_inha_key_event_encoder.sv
module tb_inha_key_event_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key_n;
   logic       ev_ready;
   logic       ev_valid;
   logic [2:0] ev_code;
   logic [7:0] key_level;
   logic       overflow;

   int vectors     = 0;
   int miscompares = 0;

   inha_key_event_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .key_n     (key_n),
      .ev_valid  (ev_valid),
      .ev_code   (ev_code),
      .ev_ready  (ev_ready),
      .key_level (key_level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // hist[k] = inverted key sample taken k+1 edges ago. With DB_CYCLES=1 the
   // debounced level after an edge equals the sample taken two edges earlier.
   logic [7:0] hist [4];
   bit   [7:0] pend;
   bit         movf;
   int         q[$];
`ifdef KEY_REPEAT_EN
   int         rcnt [8];
`endif

   task automatic model_clear();
      for (int k = 0; k < 4; k++) hist[k] = 8'h00;
      pend = '0;
      movf = 1'b0;
      q.delete();
`ifdef KEY_REPEAT_EN
      for (int k = 0; k < 8; k++) rcnt[k] = 0;
`endif
   endtask

   task automatic model_edge();
      bit         do_pop;
      int         g;
      logic [7:0] pr;
      logic [7:0] rp;
      do_pop = (q.size() > 0) && ev_ready;
      g = -1;
      for (int i = 0; i < 8; i++) if (pend[i] && g < 0) g = i;
      pr = hist[2] & ~hist[3];
      rp = 8'h00;
`ifdef KEY_REPEAT_EN
      for (int i = 0; i < 8; i++) begin
         if (hist[2][i]) begin
            rcnt[i]++;
            if (rcnt[i] == 16) begin
               rp[i]   = 1'b1;
               rcnt[i] = 0;
            end
         end else begin
            rcnt[i] = 0;
         end
      end
`endif
      if (do_pop) void'(q.pop_front());
      if (g >= 0 && (q.size() < 4)) begin
         q.push_back(g);
         pend[g] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         if (pr[i]) begin
            if (pend[i]) movf = 1'b1;
            pend[i] = 1'b1;
         end
         if (rp[i]) pend[i] = 1'b1;
      end
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = ~key_n;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_clear();
         else     model_edge();
      end
   end

   // ---------------- comparison ----------------
   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         check("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
         check("key_level", 32'(key_level), 32'(hist[2]));
         check("overflow", 32'(overflow), 32'(movf));
         if (q.size() > 0) check("ev_code", 32'(ev_code), 32'(q[0]));
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs change 2 time units after the falling edge, clear of both the
   // sampling edge and the compare instant.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic pulse(input int k);
      key_n[k] = 1'b0;
      step(1);
      key_n = 8'hFF;
      step(2);
   endtask

   int got[$];

   task automatic drain(input int max_cycles);
      got.delete();
      ev_ready = 1'b1;
      for (int c = 0; c < max_cycles; c++) begin
         if (ev_valid) got.push_back(int'(ev_code));
         step(1);
      end
      ev_ready = 1'b0;
   endtask

   int n_ev;

   initial begin
      rst      = 1'b1;
      key_n    = 8'hFF;
      ev_ready = 1'b0;
      #2;
      step(3);
      check("rst_ev_code", 32'(ev_code), 32'd0);
      rst = 1'b0;

      // 1: idle after reset
      for (int c = 0; c < 20; c++) begin
         step(1);
         check("idle_valid", 32'(ev_valid), 32'd0);
         check("idle_level", 32'(key_level), 32'd0);
         check("idle_ovf", 32'(overflow), 32'd0);
      end

      // 2: single-period pulse on U, ev_ready high
      ev_ready = 1'b1;
      key_n[2] = 1'b0;
      step(1);                 // edge N sampled the low
      key_n = 8'hFF;
      step(3);                 // after N+3
      check("u_lat_n3", 32'(ev_valid), 32'd0);
      step(1);                 // after N+4
      check("u_lat_n4", 32'(ev_valid), 32'd1);
      check("u_code", 32'(ev_code), 32'd2);
      step(1);
      check("u_one_cycle", 32'(ev_valid), 32'd0);
      ev_ready = 1'b0;
      step(5);

      // 3: L and SW0 together, drained in index order
      key_n = 8'hEE;
      step(3);
      key_n = 8'hFF;
      step(8);
      check("ls_head_valid", 32'(ev_valid), 32'd1);
      check("ls_head_code", 32'(ev_code), 32'd0);
      drain(10);
      check("ls_count", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         check("ls_first", 32'(got[0]), 32'd0);
         check("ls_second", 32'(got[1]), 32'd4);
      end
      check("ls_empty", 32'(ev_valid), 32'd0);

      // 4: fill FIFO, one pending, then lose a press
      pulse(2); pulse(0); pulse(2); pulse(0); pulse(2);
      step(8);
      check("full_valid", 32'(ev_valid), 32'd1);
      check("full_no_ovf", 32'(overflow), 32'd0);
      pulse(2);
      step(8);
      check("full_ovf", 32'(overflow), 32'd1);
      drain(14);
      check("full_count", 32'(got.size()), 32'd5);
      if (got.size() == 5) begin
         check("full_e0", 32'(got[0]), 32'd2);
         check("full_e1", 32'(got[1]), 32'd0);
         check("full_e2", 32'(got[2]), 32'd2);
         check("full_e3", 32'(got[3]), 32'd0);
         check("full_e4", 32'(got[4]), 32'd2);
      end

      // 5: hold SW3 for 40 cycles
      ev_ready = 1'b1;
      n_ev = 0;
      key_n[7] = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step(1);
         if (ev_valid && ev_code == 3'd7) n_ev++;
      end
      key_n = 8'hFF;
      for (int c = 0; c < 10; c++) begin
         step(1);
         if (ev_valid && ev_code == 3'd7) n_ev++;
      end
`ifdef KEY_REPEAT_EN
      check("hold_events", 32'(n_ev), 32'd3);
`else
      check("hold_events", 32'(n_ev), 32'd1);
`endif
      ev_ready = 1'b0;

      // 6: asynchronous reset with three queued events
      key_n = 8'hF8;
      step(2);
      key_n = 8'hFF;
      step(10);
      check("pre_rst_valid", 32'(ev_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(ev_valid), 32'd0);
      check("async_rst_ovf", 32'(overflow), 32'd0);
      check("async_rst_level", 32'(key_level), 32'd0);
      step(2);
      rst = 1'b0;
      ev_ready = 1'b1;
      n_ev = 0;
      for (int c = 0; c < 20; c++) begin
         step(1);
         if (ev_valid) n_ev++;
      end
      check("no_stale", 32'(n_ev), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
